// File: rtl/sht40_i2c_responder.sv
// I2C responder that emulates an SHT40 sensor. It accepts a measurement command, waits out a
// programmable conversion delay, then returns T_msb, T_lsb, CRC, RH_msb, RH_lsb, CRC on a read.
module sht40_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h44,
  parameter logic [7:0]  MEAS_CMD    = 8'hFD,
  parameter logic [15:0] MEAS_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_value,
  input  logic [15:0] rh_value,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        data_ready,
  output logic        busy
);

  typedef enum logic [3:0] {IDLE, ADDR, W_ACK, CMD, C_ACK, R_ACK, TX, M_ACK, IGNORE} state_t;

  state_t      state;
  logic [2:0]  scl_sr, sda_sr;
  logic        scl_s, scl_h, sda_s, sda_h;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [6:0]  shift_reg;
  logic [7:0]  rx_byte;
  logic [3:0]  bit_cnt;
  logic        ack_drv;
  logic        armed;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_byte;
  logic [15:0] meas_cnt, t_word, rh_word;
  logic [7:0]  crc_t, crc_rh;

  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign scl_s     = scl_sr[1];
  assign scl_h     = scl_sr[2];
  assign sda_s     = sda_sr[1];
  assign sda_h     = sda_sr[2];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
  assign rx_byte   = {shift_reg, sda_s};

  always_comb begin
    tx_byte = 8'h00;
    case (tx_idx)
      3'd0:    tx_byte = t_word[15:8];
      3'd1:    tx_byte = t_word[7:0];
      3'd2:    tx_byte = crc_t;
      3'd3:    tx_byte = rh_word[15:8];
      3'd4:    tx_byte = rh_word[7:0];
      3'd5:    tx_byte = crc_rh;
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scl_sr     <= 3'b111;
      sda_sr     <= 3'b111;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      ack_drv    <= 1'b0;
      armed      <= 1'b0;
      tx_idx     <= '0;
      sda_oe     <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      meas_cnt   <= '0;
      t_word     <= '0;
      rh_word    <= '0;
      crc_t      <= '0;
      crc_rh     <= '0;
    end else begin
      scl_sr    <= {scl_sr[1:0], scl_in};
      sda_sr    <= {sda_sr[1:0], sda_in};
      cmd_valid <= 1'b0;

      // CRCs are computed in the same cycle as the latch, so data_ready never precedes them
      if (busy) begin
        if (meas_cnt == MEAS_CYCLES - 16'd1) begin
          busy       <= 1'b0;
          data_ready <= 1'b1;
          t_word     <= temp_value;
          rh_word    <= rh_value;
          crc_t      <= crc8(temp_value);
          crc_rh     <= crc8(rh_value);
        end else begin
          meas_cnt <= meas_cnt + 16'd1;
        end
      end

      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        if (armed) begin
          armed      <= 1'b0;
          busy       <= 1'b1;
          data_ready <= 1'b0;
          meas_cnt   <= '0;
        end
      end else if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift_reg <= rx_byte[6:0];
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              tx_idx <= '0;
              if (rx_byte[7:1] == DEV_ADDR && !rx_byte[0])                    state <= W_ACK;
              else if (rx_byte[7:1] == DEV_ADDR && rx_byte[0] && data_ready)  state <= R_ACK;
              else                                                            state <= IGNORE;
            end
          end
          CMD: if (scl_rise) begin
            shift_reg <= rx_byte[6:0];
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              cmd_byte  <= rx_byte;
              cmd_valid <= 1'b1;
              if (rx_byte == MEAS_CMD && !busy) armed <= 1'b1;
              state <= C_ACK;
            end
          end
          W_ACK, C_ACK, R_ACK: if (scl_fall) begin
            if (!ack_drv) begin
              sda_oe  <= 1'b1;
              ack_drv <= 1'b1;
            end else begin
              ack_drv <= 1'b0;
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
              if (state == W_ACK) state <= CMD;
              else if (state == C_ACK) state <= IGNORE;
              else begin
                // ACK release and the first data bit share this falling edge
                state   <= TX;
                sda_oe  <= ~tx_byte[7];
                bit_cnt <= 4'd1;
              end
            end
          end
          TX: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= M_ACK;
            end else begin
              sda_oe  <= ~tx_byte[3'd7 - bit_cnt[2:0]];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          M_ACK: if (scl_rise) begin
            if (tx_idx == 3'd5) data_ready <= 1'b0;
            if (!sda_s) begin
              tx_idx  <= (tx_idx == 3'd5) ? 3'd0 : tx_idx + 3'd1;
              bit_cnt <= '0;
              state   <= TX;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sht40_i2c_responder.sv
// Bench for sht40_i2c_responder: a bit-banged I2C master drives the DUT and a scoreboard
// matches command pulses, ACK bits and read bytes against hand-computed expectations.
`timescale 1ns/1ps
module tb_sht40_i2c_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] temp_value = 16'h0000;
  logic [15:0] rh_value = 16'h0000;
  logic        sda_oe, cmd_valid, data_ready, busy;
  logic [7:0]  cmd_byte;
  wire         sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  sht40_i2c_responder dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .temp_value (temp_value),
    .rh_value   (rh_value),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .data_ready (data_ready),
    .busy       (busy)
  );

  typedef struct {
    int         tag;
    logic [7:0] val;
  } item_t;

  item_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         busy_total = 0;
  int         oe_total = 0;
  int         cmd_total = 0;
  logic       obs_stb = 1'b0;
  int         obs_tag = 0;
  logic [7:0] obs_val = 8'h00;

  function automatic string tag_name(input int t);
    if (t == 0) return "cmd_byte";
    if (t == 1) return "rd_byte";
    return "ack_bit";
  endfunction

  task automatic expect_item(input int tag, input logic [7:0] v);
    item_t it;
    it.tag = tag;
    it.val = v;
    exp_q.push_back(it);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic score(input int tag, input logic [7:0] v);
    item_t it;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got %h want nothing", tag_name(tag), v);
    end else begin
      it = exp_q.pop_front();
      if (it.tag != tag || it.val !== v) begin
        bad++;
        $display("FAIL %s: got %s=%h want %s=%h", tag_name(it.tag), tag_name(tag), v,
                 tag_name(it.tag), it.val);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_total++;
      if (sda_oe === 1'b1) oe_total++;
      if (cmd_valid === 1'b1) begin
        cmd_total++;
        score(0, cmd_byte);
      end
      if (obs_stb) score(obs_tag, obs_val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic observe(input int tag, input logic [7:0] v);
    obs_tag = tag;
    obs_val = v;
    obs_stb = 1'b1;
    tick(1);
    obs_stb = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(4);
    scl = 1'b1;   tick(8);
    sda_m = 1'b0; tick(8);
    scl = 1'b0;   tick(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(4);
    scl = 1'b1;   tick(8);
    sda_m = 1'b1; tick(8);
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b;  tick(4);
    scl = 1'b1; tick(8);
    scl = 1'b0; tick(4);
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; tick(4);
    scl = 1'b1;   tick(4);
    b = sda_line; tick(4);
    scl = 1'b0;   tick(4);
  endtask

  task automatic write_byte(input logic [7:0] d);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    observe(2, {7'd0, a});
  endtask

  task automatic read_byte(input logic mack);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(mack);
    observe(1, d);
  endtask

  task automatic expect_meas_write();
    expect_item(2, 8'h00);
    expect_item(0, 8'hFD);
    expect_item(2, 8'h00);
  endtask

  task automatic wait_ready(input string name, input int limit);
    int n;
    n = 0;
    while (data_ready !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, data_ready}, 32'd1);
  endtask

  logic [7:0] frame_a [7];
  logic [7:0] frame_b [7];
  int         b0, o0, c0;

  initial begin
    frame_a = '{8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93, 8'hBE};
    frame_b = '{8'h66, 8'h66, 8'h93, 8'hBE, 8'hEF, 8'h92, 8'h66};
    fork
      monitor();
    join_none

    tick(4);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(4);

    // measurement command, then an early read that must be NACKed
    temp_value = 16'hBEEF;
    rh_value   = 16'h6666;
    expect_meas_write();
    i2c_start();
    write_byte(8'h88);
    write_byte(8'hFD);
    b0 = busy_total;
    i2c_stop();
    check("busy_after_cmd", {31'd0, busy}, 32'd1);
    check("cmd_byte_held", {24'd0, cmd_byte}, 32'hFD);

    o0 = oe_total;
    expect_item(2, 8'h01);
    i2c_start();
    write_byte(8'h89);
    i2c_stop();
    check("early_read_oe_cycles", oe_total - o0, 32'd0);
    check("early_read_busy", {31'd0, busy}, 32'd1);

    wait_ready("ready_1", 3000);
    check("busy_len_1", busy_total - b0, 32'd1000);
    check("busy_clear_1", {31'd0, busy}, 32'd0);

    // six-byte read, NACK on the last byte
    expect_item(2, 8'h00);
    for (int i = 0; i < 6; i++) expect_item(1, frame_a[i]);
    i2c_start();
    write_byte(8'h89);
    for (int i = 0; i < 6; i++) begin
      read_byte(i == 5);
      if (i == 4) check("ready_before_byte5", {31'd0, data_ready}, 32'd1);
    end
    check("ready_after_byte5", {31'd0, data_ready}, 32'd0);
    i2c_stop();

    // wrong address: nothing driven, no command seen
    c0 = cmd_total;
    o0 = oe_total;
    expect_item(2, 8'h01);
    expect_item(2, 8'h01);
    i2c_start();
    write_byte(8'h8A);
    write_byte(8'hFD);
    i2c_stop();
    check("wrong_addr_cmd_count", cmd_total - c0, 32'd0);
    check("wrong_addr_oe_cycles", oe_total - o0, 32'd0);
    check("wrong_addr_busy", {31'd0, busy}, 32'd0);

    // repeated command while busy must not extend the delay
    temp_value = 16'h6666;
    rh_value   = 16'hBEEF;
    expect_meas_write();
    i2c_start();
    write_byte(8'h88);
    write_byte(8'hFD);
    b0 = busy_total;
    i2c_stop();
    tick(300);
    expect_meas_write();
    i2c_start();
    write_byte(8'h88);
    write_byte(8'hFD);
    i2c_stop();
    check("busy_during_repeat", {31'd0, busy}, 32'd1);
    wait_ready("ready_2", 3000);
    check("busy_len_2", busy_total - b0, 32'd1000);

    // read past byte 5 wraps back to byte 0
    expect_item(2, 8'h00);
    for (int i = 0; i < 7; i++) expect_item(1, frame_b[i]);
    i2c_start();
    write_byte(8'h89);
    for (int i = 0; i < 7; i++) begin
      read_byte(i == 6);
      if (i == 4) check("ready_before_wrap", {31'd0, data_ready}, 32'd1);
      if (i == 5) check("ready_after_wrap", {31'd0, data_ready}, 32'd0);
    end
    i2c_stop();

    // reset while the first data bit (0) is being driven
    expect_meas_write();
    i2c_start();
    write_byte(8'h88);
    write_byte(8'hFD);
    i2c_stop();
    wait_ready("ready_3", 3000);
    expect_item(2, 8'h00);
    i2c_start();
    write_byte(8'h89);
    @(negedge clk);
    check("tx_zero_bit_driven", {31'd0, sda_oe}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_tx_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_mid_tx_ready", {31'd0, data_ready}, 32'd0);
    rst = 1'b0;
    tick(2);
    i2c_stop();
    o0 = oe_total;
    expect_item(2, 8'h01);
    i2c_start();
    write_byte(8'h89);
    i2c_stop();
    check("post_rst_read_oe_cycles", oe_total - o0, 32'd0);

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick(1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sht40_i2c_responder.md
Name: sht40_i2c_responder

Overview:
I2C responder that emulates an SHT40 humidity/temperature sensor on a bus. It is used as the far end for the I2C master and SHT40 parser in system simulation and on-board loopback.
- Accepts a write of a measurement command.
- Runs a programmable conversion delay.
- On a later read, returns 6 bytes: T_msb, T_lsb, CRC(T), RH_msb, RH_lsb, CRC(RH).
- CRC is CRC-8, poly 0x31, init 0xFF, no reflection, no final XOR.

Parameters:
- DEV_ADDR, 7'h44, 7-bit responder address.
- MEAS_CMD, 8'hFD, the only command that starts a measurement.
- MEAS_CYCLES, 16'd1000, clk cycles from the command STOP until data is ready.

Ports:
- clk  in  1  system clock, heavily oversampled relative to SCL (at least 8x).
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  bus SCL level, asynchronous.
- sda_in  in  1  bus SDA level, asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- temp_value  in  16  raw temperature word, sampled when the measurement completes.
- rh_value  in  16  raw humidity word, sampled when the measurement completes.
- cmd_valid  out  1  one-cycle pulse when any command byte has been received.
- cmd_byte  out  8  last received command byte; held until the next command.
- data_ready  out  1  measurement data latched and not yet fully read.
- busy  out  1  measurement delay counter running.

Behaviour:
- Reset values: sda_oe=0, cmd_valid=0, cmd_byte=0, data_ready=0, busy=0, FSM=IDLE, counter=0. Reset mid-transfer releases SDA in the same cycle the reset is sampled.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer plus one history FF.
  - Edge detection uses the synchronized values.
- Bus conditions (synchronized, evaluated every clk):
  - START or repeated-START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - START from any state clears bit/byte counters and goes to ADDR.
  - STOP from any state goes to IDLE and releases SDA.
- Bit sampling: bits are sampled on SCL rising edges, MSB first.
- Driving: sda_oe changes only on SCL falling edges, so SDA is stable while SCL is high.
- FSM states and transitions:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. After the 8th rising edge, check the address:
    - addr==DEV_ADDR and R/W=0 → W_ACK. The ACK is driven even while busy; the command is then ignored.
    - addr==DEV_ADDR, R/W=1, data_ready=1 → R_ACK.
    - Any other case (wrong address, or read while data_ready=0) → IGNORE. SDA is left released, i.e. NACK.
  - W_ACK: drive 0 from the falling edge after bit 8 to the falling edge after bit 9, then → CMD.
  - CMD: shift 8 bits. On the 8th rising edge: cmd_byte<=byte and cmd_valid pulses for 1 cycle. Then → C_ACK, which always ACKs, then → IGNORE.
  - Arming: if the byte==MEAS_CMD and busy=0, the measurement is armed. At the following STOP: busy=1, data_ready=0, counter=0.
  - R_ACK: ACK as in W_ACK, then → TX with byte index 0.
  - TX: on each SCL falling edge, drive the next bit; sda_oe = ~bit. After 8 bits, release SDA → M_ACK.
  - M_ACK: sample SDA on the 9th rising edge.
    - Master ACK (0) and index<5 → index+1, TX.
    - Master ACK and index==5 → wraps to index 0 (repeats the frame).
    - Master NACK (1) → IGNORE.
    - Completing the read of byte 5 with either ACK or NACK clears data_ready.
  - IGNORE: SDA released until START or STOP.
- Measurement timing:
  - While busy, the counter increments each clk.
  - When counter==MEAS_CYCLES-1 (next clk): latch temp_value and rh_value, compute both CRCs, busy=0, data_ready=1.
  - A new MEAS_CMD while busy is ACKed but does not restart the counter.
- CRC:
  - May be computed bit-serially (16 cycles per word) after latching.
  - data_ready must not assert until both CRCs are final.
  - Known vector: data 0xBEEF → CRC 0x92.
- Simultaneous events: if START and STOP are detected in the same cycle, STOP is processed first.

Test Plan:
- Write 0x88 (addr 0x44, W), then 0xFD, then STOP → ACK after both bytes; cmd_valid pulses once with cmd_byte=0xFD; busy=1 for exactly MEAS_CYCLES clk; then data_ready=1.
- Set temp=0xBEEF, rh=0x6666, measure, then read 0x89 with 6 bytes (master ACK×5, NACK) → bytes BE EF 92 66 66 93; data_ready=0 after byte 5.
- Read 0x89 before the delay expires → address NACK (SDA stays high on the 9th clock); no data is driven; busy is unaffected.
- Write to address 0x45 → NACK; cmd_valid never pulses; sda_oe stays 0 for the whole transaction.
- Send 0xFD again while busy → ACK and cmd_valid pulse, but the busy duration is not extended (ready at the original time).
- Assert rst while TX is driving a 0 bit → sda_oe=0 in the next cycle; next valid read is NACKed because data_ready=0.
